button_pulser: RTL and testbench
================================

# button_pulser

Input conditioner that drives the game core's `button` bus. It takes raw, asynchronous, bouncing pushbutton levels and turns them into synchronized, debounced levels plus single-cycle press pulses. The game FSMs consume one event per physical press, so this block is the producing end of the button interface. It sits between the pad inputs and the game core, and its `enable` input is tied to the inverted chip select.

## Interface
- `NUM_BTN`, default 4: number of buttons.
- `DB_CYCLES`, default 16: number of consecutive cycles a synchronized level must differ from the debounced level before that level is accepted. Must be ≥ 2.
- `REPEAT_DELAY`, default 64: cycles from the initial press pulse to the first repeat pulse. Used only with `BTN_REPEAT_EN`.
- `REPEAT_PERIOD`, default 16: cycles between successive repeat pulses. Used only with `BTN_REPEAT_EN`.
- `REPEAT_MASK`, default 4'b0011: per-button repeat enable. Used only with `BTN_REPEAT_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_raw`  in  NUM_BTN  raw pushbutton levels, asynchronous, 1 = pressed.
- `enable`  in  1  when low, pulses are suppressed.
- `btn_level`  out  NUM_BTN  debounced level.
- `btn_pulse`  out  NUM_BTN  one-cycle press event per button.
- `any_pulse`  out  1  OR of `btn_pulse`.

## Operation
- Each bit runs through a 2-flop synchronizer; the second flop's output is `s`.
- Each button has a debounce counter of width $clog2(DB_CYCLES).
  - `s == btn_level`: counter is cleared to 0.
  - `s != btn_level` and counter < DB_CYCLES-1: counter increments.
  - `s != btn_level` and counter == DB_CYCLES-1: `btn_level` takes `s` and the counter clears.
- Any agreement cycle restarts the count. Bounce shorter than DB_CYCLES cycles never changes `btn_level`.
- `btn_pulse[i]` is registered. It is set for exactly one cycle on the edge where `btn_level[i]` goes 0→1 while `enable` = 1.
- A falling `btn_level` never produces a pulse.
- Buttons are independent. Simultaneous qualifying presses pulse in the same cycle.
- `enable` = 0:
  - `btn_pulse` is forced to 0.
  - Debounce tracking and `btn_level` continue normally.
  - A press whose rising edge occurs while disabled is lost. A later rise of `enable` does not replay it.
- Reset: synchronizers, `btn_level`, `btn_pulse`, `any_pulse` and all counters become 0.
  - A button held through reset release is treated as a new press and pulses after the normal latency.
  - Reset asserted mid-debounce discards the partial count.

## Timing
- Latency: `btn_raw` rises before clock edge 1 and stays stable. `btn_level` and `btn_pulse` go high at edge 2+DB_CYCLES. The pulse drops at the next edge.
- Release latency is identical for `btn_level`.
- `any_pulse` is combinational from `btn_pulse`. It adds no extra cycle.
- Minimum spacing between two press pulses on one button is 2·DB_CYCLES cycles: release debounce plus press debounce.

## Configuration
- `BTN_REPEAT_EN` defined:
  - Each button with its `REPEAT_MASK` bit set has a repeat counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - While `btn_level[i]` = 1 and `enable` = 1, an additional `btn_pulse[i]` fires REPEAT_DELAY cycles after the initial pulse. Further pulses follow every REPEAT_PERIOD cycles.
  - Release, `enable` = 0 or `rst` clears the repeat counter. Re-enabling while held does not resume repeating until the next fresh press.
- `BTN_REPEAT_EN` undefined:
  - No repeat logic is built. The REPEAT_* parameters are ignored.
  - Exactly one pulse per debounced press.

## Test plan
- Clean press, DB_CYCLES=4: raw bit0 rises before edge 1 and holds → `btn_pulse`=4'b0001 and `any_pulse`=1 only in the cycle after edge 6; `btn_level[0]`=1 from edge 6.
- Bounce, DB_CYCLES=4: raw toggles 1,0,1,0 with 3-cycle high segments → no pulse and `btn_level` stays 0; then a steady high → exactly one pulse.
- Simultaneous: bits 0 and 2 rise together → `btn_pulse`=4'b0101 for one cycle; releasing both → no pulse and `btn_level`=0 after 2+DB_CYCLES edges.
- Enable gating: press with `enable`=0 → `btn_level`=1 but `btn_pulse`=0; raise `enable` while still held → no pulse; release and press again with `enable`=1 → one pulse.
- Reset: assert `rst` mid-debounce → all outputs 0 the next cycle; release `rst` with the button held → pulse at edge 2+DB_CYCLES after release.
- With `BTN_REPEAT_EN`, REPEAT_DELAY=8, REPEAT_PERIOD=4: hold bit0 → pulses at initial+8, +12, +16; hold bit3 (mask 0) → a single pulse only.

Source files
------------

// File: rtl/button_pulser.sv
// Pushbutton conditioner: 2-flop sync, debounce, registered press pulses.
// Define BTN_REPEAT_EN to add auto-repeat pulses on buttons in REPEAT_MASK.
module button_pulser #(
  parameter int NUM_BTN       = 4,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = 4'b0011
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               enable,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_pulse
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic [NUM_BTN-1:0] rise;
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    rise = level_d & ~level_q;
  end

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0]      rcnt_q [NUM_BTN];
  logic [RW-1:0]      rcnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] ract_q, ract_d;
  logic [NUM_BTN-1:0] rep;

  // Repeat arms only on a fresh enabled press; any break disarms it.
  always_comb begin
    ract_d = ract_q;
    rep    = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rcnt_d[i] = rcnt_q[i];
      if (!REPEAT_MASK[i] || !enable || !level_d[i]) begin
        ract_d[i] = 1'b0;
        rcnt_d[i] = '0;
      end else if (rise[i]) begin
        ract_d[i] = 1'b1;
        rcnt_d[i] = RW'(REPEAT_DELAY - 1);
      end else if (ract_q[i]) begin
        if (rcnt_q[i] == '0) begin
          rep[i]    = 1'b1;
          rcnt_d[i] = RW'(REPEAT_PERIOD - 1);
        end else begin
          rcnt_d[i] = rcnt_q[i] - RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ract_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) rcnt_q[i] <= '0;
    end else begin
      ract_q <= ract_d;
      for (int i = 0; i < NUM_BTN; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

  assign pulse_d = enable ? (rise | rep) : '0;
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0]};

  assign pulse_d = enable ? rise : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign any_pulse = |pulse_q;

endmodule

// File: tb/tb_button_pulser.sv
// Scoreboard bench for button_pulser (DB_CYCLES=4, repeat 8/4).
// Expected pulses are queued by stimulus and checked by a monitor.
module tb_button_pulser;

  localparam int NB  = 4;
  localparam int DB  = 4;
  localparam int LAT = 2 + DB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          any_pulse;

  button_pulser #(
    .NUM_BTN      (NB),
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4),
    .REPEAT_MASK  (4'b0011)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .enable   (enable),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          cyc;
    logic [NB-1:0] m;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int c, input logic [NB-1:0] m);
    exp_t e;
    e.cyc = c;
    e.m   = m;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (btn_pulse != '0 || any_pulse)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {27'd0, any_pulse, btn_pulse}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_edge", edge_n, e.cyc);
        chk("pulse_val", btn_pulse, e.m);
        chk("any_pulse", any_pulse, 1);
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_level", btn_level, 0);
    chk("rst_pulse", btn_pulse, 0);
    chk("rst_any", any_pulse, 0);
    rst = 1'b0;
    tick(2);

    // clean press and release
    btn_raw = 4'b0001;
    expect_pulse(edge_n + LAT, 4'b0001);
    tick(LAT - 1);
    chk("t1_level_pre", btn_level, 0);
    tick(1);
    chk("t1_level", btn_level, 4'b0001);
    btn_raw = 4'b0000;
    tick(LAT - 1);
    chk("t1_rel_pre", btn_level, 4'b0001);
    tick(1);
    chk("t1_rel", btn_level, 0);
    tick(4);

    // bounce with 3-cycle segments, then steady
    for (int k = 0; k < 2; k++) begin
      btn_raw = 4'b0001;
      tick(3);
      btn_raw = 4'b0000;
      tick(3);
    end
    chk("t2_bounce_level", btn_level, 0);
    btn_raw = 4'b0001;
    expect_pulse(edge_n + LAT, 4'b0001);
    tick(LAT);
    chk("t2_level", btn_level, 4'b0001);
    btn_raw = 4'b0000;
    tick(LAT + 4);
    chk("t2_rel", btn_level, 0);

    // simultaneous press and release
    btn_raw = 4'b0101;
    expect_pulse(edge_n + LAT, 4'b0101);
    tick(LAT);
    chk("t3_level", btn_level, 4'b0101);
    btn_raw = 4'b0000;
    tick(LAT - 1);
    chk("t3_rel_pre", btn_level, 4'b0101);
    tick(1);
    chk("t3_rel", btn_level, 0);
    tick(4);

    // enable gating
    enable  = 1'b0;
    btn_raw = 4'b0001;
    tick(LAT);
    chk("t4_level_dis", btn_level, 4'b0001);
    chk("t4_pulse_dis", btn_pulse, 0);
    enable = 1'b1;
    tick(4);
    chk("t4_pulse_reen", btn_pulse, 0);
    btn_raw = 4'b0000;
    tick(LAT + 2);
    chk("t4_rel", btn_level, 0);
    btn_raw = 4'b0001;
    expect_pulse(edge_n + LAT, 4'b0001);
    tick(LAT);
    btn_raw = 4'b0000;
    tick(LAT + 4);

    // reset mid-debounce, button held through release
    btn_raw = 4'b0010;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_level", btn_level, 0);
    chk("t5_rst_pulse", btn_pulse, 0);
    chk("t5_rst_any", any_pulse, 0);
    tick(1);
    rst = 1'b0;
    expect_pulse(edge_n + LAT, 4'b0010);
    tick(LAT - 1);
    chk("t5_level_pre", btn_level, 0);
    tick(1);
    chk("t5_level", btn_level, 4'b0010);
    btn_raw = 4'b0000;
    tick(LAT + 4);

    // long hold on bit0 (repeat) and bit3 (no repeat)
    btn_raw = 4'b1001;
    expect_pulse(edge_n + LAT, 4'b1001);
`ifdef BTN_REPEAT_EN
    expect_pulse(edge_n + LAT + 8, 4'b0001);
    expect_pulse(edge_n + LAT + 12, 4'b0001);
    expect_pulse(edge_n + LAT + 16, 4'b0001);
`endif
    tick(20);
    chk("t6_level", btn_level, 4'b1001);
    btn_raw = 4'b0000;
    tick(LAT + 4);
    chk("t6_rel", btn_level, 0);

    tick(10);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
